// File: rtl/ps2_scan_rx_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
// Frame and code FSM encodings plus frame-check helper.
package ps2_scan_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } frame_state_t;

  typedef enum logic {
    WAIT_BRK,
    GET_CODE
  } code_state_t;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam int         FRAME_BITS = 11;

  // f = {stop, parity, data[7:0]}; odd parity and stop high
  function automatic logic frame_ok(input logic [9:0] f);
    return (^f[8:0]) & f[9];
  endfunction

endpackage

// File: rtl/ps2_scan_rx_frame.sv
// PS/2 line conditioning and frame receiver: sync, glitch filter,
// frame FSM with inter-edge watchdog.
module ps2_frame_rx
  import ps2_scan_rx_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  output logic       byte_valid,
  output logic [7:0] data_byte,
  output logic       frame_err
);

  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);
  localparam logic [WDW-1:0] WD_ONE  = WDW'(1);

  logic [1:0]   psc_sync_q, psc_sync_d;
  logic [1:0]   psd_sync_q, psd_sync_d;
  logic [7:0]   filt_q, filt_d;
  logic         flt_q, flt_d;
  logic         fall_tick;
  logic         din;

  frame_state_t state_q, state_d;
  logic [3:0]   bits_q, bits_d;
  logic [9:0]   sh_q, sh_d;
  logic [WDW-1:0] wd_q, wd_d;

  always_comb begin
    psc_sync_d = {psc_sync_q[0], ps2c};
    psd_sync_d = {psd_sync_q[0], ps2d};
    filt_d     = {filt_q[6:0], psc_sync_q[1]};
    flt_d      = flt_q;
    if (filt_q == 8'hFF) begin
      flt_d = 1'b1;
    end else if (filt_q == 8'h00) begin
      flt_d = 1'b0;
    end
  end

  assign fall_tick = flt_q & ~flt_d;
  assign din       = psd_sync_q[1];

  always_comb begin
    state_d    = state_q;
    bits_d     = bits_q;
    sh_d       = sh_q;
    wd_d       = '0;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall_tick && !din) begin
          state_d = SHIFT;
          bits_d  = 4'(FRAME_BITS - 1);
          wd_d    = WD_ONE;
        end
      end
      SHIFT: begin
        if (fall_tick) begin
          sh_d   = {din, sh_q[9:1]};
          bits_d = bits_q - 4'd1;
          wd_d   = WD_ONE;
          if (bits_q == 4'd1) begin
            state_d = CHECK;
          end
        end else if (wd_q == WD_LAST) begin
          frame_err = 1'b1;
          state_d   = IDLE;
          bits_d    = '0;
          sh_d      = '0;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (frame_ok(sh_q)) begin
          byte_valid = 1'b1;
        end else begin
          frame_err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_byte = sh_q[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      psc_sync_q <= 2'b11;
      psd_sync_q <= 2'b11;
      filt_q     <= 8'hFF;
      flt_q      <= 1'b1;
      state_q    <= IDLE;
      bits_q     <= '0;
      sh_q       <= '0;
      wd_q       <= '0;
    end else begin
      psc_sync_q <= psc_sync_d;
      psd_sync_q <= psd_sync_d;
      filt_q     <= filt_d;
      flt_q      <= flt_d;
      state_q    <= state_d;
      bits_q     <= bits_d;
      sh_q       <= sh_d;
      wd_q       <= wd_d;
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver reporting released-key scan codes
// (code following a 0xF0 break prefix).
module ps2_scan_rx
  import ps2_scan_rx_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  output logic [7:0] key_code,
  output logic       got_code_tick,
  output logic       frame_err
);

  logic        byte_valid;
  logic [7:0]  rx_byte;
  logic        rx_err;

  code_state_t code_q, code_d;
  logic [7:0]  key_q, key_d;
  logic        tick_q, tick_d;
  logic        err_q, err_d;

  ps2_frame_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_frame (
    .clk       (clk),
    .reset     (reset),
    .ps2d      (ps2d),
    .ps2c      (ps2c),
    .byte_valid(byte_valid),
    .data_byte (rx_byte),
    .frame_err (rx_err)
  );

  always_comb begin
    code_d = code_q;
    key_d  = key_q;
    tick_d = 1'b0;
    err_d  = rx_err;
    if (rx_err) begin
      code_d = WAIT_BRK;
    end else if (byte_valid) begin
      unique case (code_q)
        WAIT_BRK: begin
          // extended prefix and make codes leave us waiting
          unique case (1'b1)
            (rx_byte == BREAK_CODE): code_d = GET_CODE;
            (rx_byte == EXT_CODE):   code_d = WAIT_BRK;
            default:                 code_d = WAIT_BRK;
          endcase
        end
        GET_CODE: begin
          key_d  = rx_byte;
          tick_d = 1'b1;
          code_d = WAIT_BRK;
        end
        default: code_d = WAIT_BRK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q <= WAIT_BRK;
      key_q  <= '0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      code_q <= code_d;
      key_q  <= key_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  assign key_code      = key_q;
  assign got_code_tick = tick_q;
  assign frame_err     = err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx with a pulse scoreboard.
// 1 MHz-equivalent clk cycles, 80-cycle PS/2 bit (12.5 kHz).
module tb_ps2_scan_rx;

  localparam int TO   = 100;
  localparam int HALF = 40;
  // ps2c drive to fall_tick cycle: 2 sync + 8 filter stages
  localparam int LAT  = 10;
  localparam int K_TICK = 1;
  localparam int K_ERR  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2d;
  logic       ps2c;
  logic [7:0] key_code;
  logic       got_code_tick;
  logic       frame_err;

  ps2_scan_rx #(
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2d         (ps2d),
    .ps2c         (ps2c),
    .key_code     (key_code),
    .got_code_tick(got_code_tick),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [7:0] code;
    int         at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int total = 0;
  int bad = 0;
  logic [7:0] m_key;
  bit m_brk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (got_code_tick === 1'b1 || frame_err === 1'b1) begin
      chk("both_pulses", 32'(got_code_tick & frame_err), 32'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", {30'd0, got_code_tick, frame_err},
            32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("pulse_kind", got_code_tick ? K_TICK : K_ERR, mon_e.kind);
        chk("pulse_cycle", cyc, mon_e.at);
        if (got_code_tick) begin
          chk("tick_code", 32'(key_code), 32'(mon_e.code));
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit flip,
                      input int n, input int kind, input int lat);
    logic [10:0] f;
    exp_t e;
    f = {1'b1, (~^d) ^ flip, d, 1'b0};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2d = f[i];
      repeat (HALF) @(negedge clk);
      ps2c = 1'b0;
      if (i == n - 1 && kind != 0) begin
        e.kind = kind;
        e.code = d;
        e.at   = cyc + lat;
        sbq.push_back(e);
      end
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] d, input bit flip);
    int k;
    k = 0;
    if (flip) begin
      k = K_ERR;
      m_brk = 1'b0;
    end else if (m_brk) begin
      k = K_TICK;
      m_key = d;
      m_brk = 1'b0;
    end else begin
      m_brk = (d == 8'hF0);
    end
    send(d, flip, 11, k, LAT + 2);
    chk("key_level", 32'(key_code), 32'(m_key));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_key = 8'h00;
    m_brk = 1'b0;
    @(negedge clk);
    chk("key_after_reset", 32'(key_code), 32'h00);
  endtask

  initial begin
    reset = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    m_key = 8'h00;
    m_brk = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_key", 32'(key_code), 32'h00);
    chk("rst_tick", 32'(got_code_tick), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);

    // short low glitch while idle
    ps2c = 1'b0;
    repeat (3) @(negedge clk);
    ps2c = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_key", 32'(key_code), 32'h00);
    chk("glitch_sbq", sbq.size(), 32'd0);

    frame(8'h05, 1'b0);
    frame(8'hF0, 1'b0);
    frame(8'h05, 1'b0);

    frame(8'hE0, 1'b0);
    frame(8'hF0, 1'b0);
    frame(8'h79, 1'b0);
    frame(8'h06, 1'b0);

    frame(8'hF0, 1'b0);
    frame(8'h04, 1'b1);
    frame(8'h06, 1'b0);

    // abort after 4 edges: watchdog expires TO cycles later
    send(8'h3A, 1'b0, 4, K_ERR, LAT + TO);
    m_brk = 1'b0;
    repeat (TO) @(negedge clk);
    chk("timeout_key", 32'(key_code), 32'(m_key));
    frame(8'hF0, 1'b0);
    frame(8'h04, 1'b0);

    frame(8'hF0, 1'b0);
    do_reset();
    frame(8'h05, 1'b0);

    // reset in the middle of a frame
    send(8'h55, 1'b0, 4, 0, 0);
    do_reset();
    frame(8'hF0, 1'b0);
    frame(8'h1C, 1'b0);

    repeat (50) @(negedge clk);
    chk("sbq_drained", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
